// File: rtl/uni_bitstream_decoder_pkg.sv
// Shared types and helpers for the unipolar bitstream decoder: FSM states,
// default window/output sizes and the count-to-output scaling function.
package uni_dec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } dec_state_e;

  localparam int WIN_LOG2_DEF = 8;
  localparam int DATA_W_DEF   = 8;

  // An all-ones window counts to exactly 2^win_log2, which would overflow the
  // scaled output by one, so it is clamped to the largest output code.
  function automatic logic [31:0] sat_scale(input logic [31:0] cnt,
                                            input int          win_log2,
                                            input int          data_w);
    logic [31:0] res;
    if (cnt >= (32'd1 << win_log2)) begin
      res = (32'd1 << data_w) - 32'd1;
    end else begin
      res = cnt >> (win_log2 - data_w);
    end
    return res;
  endfunction

endpackage

// File: rtl/uni_bitstream_decoder_if.sv
// Stream-in / result-out bundle of the bitstream decoder.
// The iAbort wire exists only when UNI_DEC_ABORT_EN is defined.
interface uni_bitstream_decoder_if #(
  parameter int DATA_W = 8
);
  logic              iStart;
  logic              iBit;
  logic              iBitValid;
  logic              iReady;
  logic [DATA_W-1:0] oData;
  logic              oValid;
  logic              oBusy;
`ifdef UNI_DEC_ABORT_EN
  logic              iAbort;
`endif

  modport master (
    output iStart, iBit, iBitValid, iReady,
`ifdef UNI_DEC_ABORT_EN
    output iAbort,
`endif
    input  oData, oValid, oBusy
  );

  modport slave (
    input  iStart, iBit, iBitValid, iReady,
`ifdef UNI_DEC_ABORT_EN
    input  iAbort,
`endif
    output oData, oValid, oBusy
  );

endinterface

// File: rtl/uni_bitstream_decoder_win_cnt.sv
// Window index counter: counts accepted bits and flags the last slot (W-1).
module uni_win_cnt #(
  parameter int WIN_LOG2 = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic iClr,
  input  logic iEn,
  output logic oLast
);

  logic [WIN_LOG2-1:0] idx_q;
  logic [WIN_LOG2-1:0] idx_d;

  always_comb begin
    idx_d = idx_q;
    if (iClr) begin
      idx_d = '0;
    end else if (iEn) begin
      idx_d = idx_q + WIN_LOG2'(1);
    end else begin
      idx_d = idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign oLast = &idx_q;

endmodule

// File: rtl/uni_bitstream_decoder.sv
// Counts ones over a 2^WIN_LOG2-bit window and presents the scaled result with
// a valid/ready handshake. Optional abort input under UNI_DEC_ABORT_EN.
module uni_bitstream_decoder
  import uni_dec_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  uni_bitstream_decoder_if.slave  bus
);

  dec_state_e          state_q, state_d;
  logic [WIN_LOG2:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                win_clr_s;
  logic                win_en_s;
  logic                win_last_s;
  logic                abort_s;

`ifdef UNI_DEC_ABORT_EN
  assign abort_s = bus.iAbort;
`else
  assign abort_s = 1'b0;
`endif

  uni_win_cnt #(.WIN_LOG2(WIN_LOG2)) u_win_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .iClr  (win_clr_s),
    .iEn   (win_en_s),
    .oLast (win_last_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    win_clr_s = 1'b0;
    win_en_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.iStart) begin
          state_d   = ACC;
          cnt_d     = '0;
          win_clr_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        // Abort wins over a window that would otherwise complete this cycle.
        if (abort_s) begin
          state_d = IDLE;
        end else if (bus.iBitValid) begin
          cnt_d    = cnt_q + (WIN_LOG2 + 1)'(bus.iBit);
          win_en_s = 1'b1;
          if (win_last_s) begin
            state_d = HOLD;
            data_d  = DATA_W'(sat_scale(32'(cnt_d), WIN_LOG2, DATA_W));
          end else begin
            state_d = ACC;
          end
        end else begin
          state_d = ACC;
        end
      end
      HOLD: begin
        if (bus.iReady && bus.iStart) begin
          state_d   = ACC;
          cnt_d     = '0;
          win_clr_s = 1'b1;
        end else if (bus.iReady) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    valid_d = (state_d == HOLD);
    busy_d  = (state_d == ACC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.oData  = data_q;
  assign bus.oValid = valid_q;
  assign bus.oBusy  = busy_q;

endmodule

// File: tb/tb_uni_bitstream_decoder.sv
// Directed bench for uni_bitstream_decoder (W=256, DATA_W=8); the abort steps
// run only when UNI_DEC_ABORT_EN is defined.
module tb_uni_bitstream_decoder;

  localparam int PAT_ZERO = 0;
  localparam int PAT_ONE  = 1;
  localparam int PAT_ALT  = 2;
  localparam int PAT_SOB  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  uni_bitstream_decoder_if #(.DATA_W(8)) bus ();

  uni_bitstream_decoder #(.WIN_LOG2(8), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Stream bit n of a pattern; the Sobol case is a comparator of 100 against
  // the first Sobol dimension (8-bit bit-reversed index).
  function automatic logic gen_bit(input int pat, input int n);
    logic [7:0] idx;
    logic [7:0] rev;
    idx = n[7:0];
    for (int k = 0; k < 8; k++) rev[k] = idx[7-k];
    case (pat)
      PAT_ZERO: return 1'b0;
      PAT_ONE:  return 1'b1;
      PAT_ALT:  return ~idx[0];
      default:  return (8'd100 > rev);
    endcase
  endfunction

  task automatic run_window(input string tag, input bit do_start, input int pat,
                            input bit gap, input logic [7:0] exp);
    int n;
    int cyc;
    if (do_start) begin
      bus.iStart = 1'b1;
      tick();
      bus.iStart = 1'b0;
      chk({tag, "_busy"}, 32'(bus.oBusy), 32'd1);
    end
    n = 0;
    cyc = 0;
    while (n < 256 && cyc < 2000) begin
      cyc++;
      if (gap && (cyc % 3 == 0)) begin
        bus.iBitValid = 1'b0;
        bus.iBit      = 1'b1;
      end else begin
        bus.iBitValid = 1'b1;
        bus.iBit      = gen_bit(pat, n);
        if (n == 255) chk({tag, "_early_valid"}, 32'(bus.oValid), 32'd0);
        n++;
      end
      tick();
    end
    bus.iBitValid = 1'b0;
    bus.iBit      = 1'b0;
    chk({tag, "_bits_sent"}, 32'(n), 32'd256);
    chk({tag, "_valid"}, 32'(bus.oValid), 32'd1);
    chk({tag, "_busy_end"}, 32'(bus.oBusy), 32'd0);
    chk({tag, "_data"}, 32'(bus.oData), 32'(exp));
  endtask

  task automatic accept(input string tag);
    bus.iReady = 1'b1;
    tick();
    bus.iReady = 1'b0;
    chk({tag, "_acc_valid"}, 32'(bus.oValid), 32'd0);
    chk({tag, "_acc_busy"}, 32'(bus.oBusy), 32'd0);
  endtask

  task automatic feed_bits(input int count, input int pat);
    for (int i = 0; i < count; i++) begin
      bus.iBitValid = 1'b1;
      bus.iBit      = gen_bit(pat, i);
      tick();
    end
    bus.iBitValid = 1'b0;
    bus.iBit      = 1'b0;
  endtask

  initial begin
    bus.iStart    = 1'b0;
    bus.iBit      = 1'b0;
    bus.iBitValid = 1'b0;
    bus.iReady    = 1'b0;
`ifdef UNI_DEC_ABORT_EN
    bus.iAbort    = 1'b0;
`endif
    #2;
    chk("rst_data", 32'(bus.oData), 32'd0);
    chk("rst_valid", 32'(bus.oValid), 32'd0);
    chk("rst_busy", 32'(bus.oBusy), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Bits presented in IDLE must not be counted.
    bus.iBitValid = 1'b1;
    bus.iBit      = 1'b1;
    tick();
    tick();
    bus.iBitValid = 1'b0;
    chk("idle_busy", 32'(bus.oBusy), 32'd0);

    run_window("ones", 1'b1, PAT_ONE, 1'b0, 8'd255);
    accept("ones");
    run_window("zeros", 1'b1, PAT_ZERO, 1'b0, 8'd0);
    accept("zeros");
    run_window("alt", 1'b1, PAT_ALT, 1'b0, 8'd128);
    accept("alt");
    run_window("sobol", 1'b1, PAT_SOB, 1'b0, 8'd100);
    accept("sobol");
    run_window("gap", 1'b1, PAT_SOB, 1'b1, 8'd100);

    // Backpressure: result must hold; a lone iStart in HOLD is dropped.
    for (int i = 0; i < 10; i++) begin
      bus.iStart = (i == 4);
      tick();
      chk("bp_valid", 32'(bus.oValid), 32'd1);
      chk("bp_data", 32'(bus.oData), 32'd100);
    end
    bus.iStart = 1'b0;
    chk("bp_busy", 32'(bus.oBusy), 32'd0);
    bus.iReady = 1'b1;
    bus.iStart = 1'b1;
    tick();
    bus.iReady = 1'b0;
    bus.iStart = 1'b0;
    chk("b2b_valid", 32'(bus.oValid), 32'd0);
    chk("b2b_busy", 32'(bus.oBusy), 32'd1);
    run_window("b2b", 1'b0, PAT_ALT, 1'b0, 8'd128);
    accept("b2b");

    // Asynchronous reset in the middle of a window.
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    feed_bits(100, PAT_ONE);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_data", 32'(bus.oData), 32'd0);
    chk("mrst_valid", 32'(bus.oValid), 32'd0);
    chk("mrst_busy", 32'(bus.oBusy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mrst_idle_busy", 32'(bus.oBusy), 32'd0);
    run_window("after_rst", 1'b1, PAT_SOB, 1'b0, 8'd100);
    accept("after_rst");

`ifdef UNI_DEC_ABORT_EN
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    feed_bits(100, PAT_ONE);
    bus.iAbort = 1'b1;
    tick();
    bus.iAbort = 1'b0;
    chk("abort_busy", 32'(bus.oBusy), 32'd0);
    chk("abort_valid", 32'(bus.oValid), 32'd0);
    tick();
    chk("abort_valid2", 32'(bus.oValid), 32'd0);
    // Abort coinciding with the completing bit must still win.
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    feed_bits(255, PAT_ONE);
    bus.iBitValid = 1'b1;
    bus.iBit      = 1'b1;
    bus.iAbort    = 1'b1;
    tick();
    bus.iBitValid = 1'b0;
    bus.iAbort    = 1'b0;
    chk("abort_last_valid", 32'(bus.oValid), 32'd0);
    chk("abort_last_busy", 32'(bus.oBusy), 32'd0);
    run_window("after_abort", 1'b1, PAT_ALT, 1'b0, 8'd128);
    accept("after_abort");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uni_bitstream_decoder.md
# uni_bitstream_decoder

Converts a unipolar stochastic or unary bitstream back to binary by counting ones over a fixed window of 2^WIN_LOG2 valid bits. This is the receive end of the MAC output path: the bitstream produced by the MAC's comparator (sum > Sobol sequence) enters here, and the decoded binary value is presented to downstream logic with a valid/ready handshake. Accumulation starts on a start pulse. The result is held until it is accepted.

## Interface
Parameters:
- WIN_LOG2, default 8: log2 of the window length W in valid bits; must satisfy WIN_LOG2 >= DATA_W.
- DATA_W, default 8: width of the decoded output.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- iStart  in  1  single-cycle pulse that starts a new window.
- iBit  in  1  stream bit.
- iBitValid  in  1  iBit is sampled this cycle.
- iReady  in  1  downstream accepts oData.
- oData  out  DATA_W  decoded value.
- oValid  out  1  oData is valid; held until accepted.
- oBusy  out  1  a window is accumulating.
- iAbort  in  1  present only with UNI_DEC_ABORT_EN.

## Operation
- State machine with three states: IDLE, ACC, HOLD. Reset enters IDLE.
- IDLE:
  - iStart moves the block to ACC.
  - On that transition, the ones counter (WIN_LOG2+1 bits) and the window index (WIN_LOG2 bits) clear.
  - iBit is ignored in IDLE.
- ACC:
  - Each cycle with iBitValid=1, the ones counter adds iBit and the window index increments.
  - Cycles with iBitValid=0 change nothing.
  - When a valid bit arrives with window index = W-1, the result register loads and the state moves to HOLD.
  - iStart is ignored in ACC.
- Result arithmetic:
  - oData = count >> (WIN_LOG2-DATA_W).
  - If count = W (all ones), oData saturates to all-ones (2^DATA_W - 1).
  - The counter never wraps.
- HOLD:
  - oValid=1 and oData is stable.
  - On iReady=1, the state moves to IDLE.
  - If iStart=1 in the same cycle as iReady=1, the state moves directly to ACC with counters cleared (back-to-back windows).
  - iStart without iReady is ignored and not queued.
- oBusy=1 exactly while in ACC.

## Timing
- Reset values: oData=0, oValid=0, oBusy=0, state IDLE, counters 0.
- Reset asserted in any state returns the block to IDLE immediately. The partial window is discarded.
- iStart sampled at cycle 0 gives ACC from cycle 1. The first bit is sampled at cycle 1.
- With continuous iBitValid, the W-th bit is sampled at cycle W and oValid rises at cycle W+1.
- In general, oValid rises one cycle after the W-th valid bit.
- Handshake: transfer occurs on the clock edge where oValid=1 and iReady=1. oValid falls on the next cycle unless a new window has already completed, which cannot happen because HOLD stalls accumulation.
- Minimum period between back-to-back results is W+1 cycles.

## Configuration
- UNI_DEC_ABORT_EN defined:
  - The iAbort port exists.
  - iAbort=1 in ACC returns the block to IDLE on the next edge, discards the count, and produces no oValid.
  - iAbort has priority over a completing W-th bit in the same cycle.
  - iAbort is ignored in IDLE and HOLD.
- Not defined: the port is absent and a started window always completes.

## Structure
- Package uni_dec_pkg holds:
  - The state enum typedef (IDLE, ACC, HOLD).
  - Default WIN_LOG2/DATA_W localparams.
  - A saturate-and-scale function for count-to-oData.
- Sub-module uni_win_cnt holds the window index counter. It has clear and enable (iBitValid & ACC) inputs and a terminal flag (index = W-1).

## Test plan
- W=256, DATA_W=8, 256 valid ones -> oData=255 (saturated), oValid at cycle 257 after iStart.
- 256 zeros -> oData=0. Alternating 1,0 stream -> oData=128.
- Stream from a comparator of value 100 against the 8-bit Sobol sequence over its full period -> oData=100 exactly.
- iBitValid low on every third cycle -> result unchanged versus gap-free stream; oValid one cycle after the 256th valid bit.
- Backpressure: iReady low 10 cycles in HOLD -> oData/oValid stable. Then iReady and iStart together -> oValid drops, oBusy=1 next cycle, second result correct.
- rst_n low mid-ACC at bit 100 -> all outputs 0 and IDLE. With UNI_DEC_ABORT_EN, iAbort at bit 100 -> IDLE, no oValid, next window decodes correctly.
